// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX/RX paths.
//   - wishbone register address map
//   - RX receiver FSM state encoding
//   - line levels and the reset default for the bit-rate divider
package uart_pkg;

  localparam logic [1:0] TX_DATA_ADDR   = 2'b00;
  localparam logic [1:0] RX_DATA_ADDR   = 2'b01;
  localparam logic [1:0] FREQ_DIV_ADDR  = 2'b10;
  localparam logic [1:0] RX_STATUS_ADDR = 2'b11;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Reset value of the frequency-divider register (oversample period - 1).
  localparam logic [7:0] FREQ_DIV_RST = 8'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO for received UART characters.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   push, data_in   - write a byte (ignored when full unless popping too)
//   pop             - drop the head byte (ignored when empty)
//   data_out        - registered head byte; 0 after reset, holds last value when empty
//   full, empty     - occupancy flags
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   cnt_q;
  logic [7:0]    head_q, head_d;
  logic          do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_nxt   = rd_ptr_q + AW'(1);
  assign data_out = head_q;

  // The head is kept in its own register so the output is reset to 0 and
  // keeps the last byte once the FIFO drains.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (cnt_q == (AW+1)'(1)) begin
        // Last entry leaves; a simultaneous push becomes the new head.
        if (do_push) head_d = data_in;
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end else if (empty && do_push) begin
      head_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      head_q <= head_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 UART receiver with a show-ahead RX FIFO.
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   rx_bit        - asynchronous serial input, idle high
//   freq_divider  - oversample tick period minus one, in clk cycles
//   rx_pop        - pop the FIFO head
//   clear_err     - clear sticky error flags
//   rx_data_out   - FIFO head byte
//   rx_empty, rx_full - FIFO status
//   frame_error   - sticky: stop bit sampled low
//   overrun       - sticky: byte dropped because the FIFO was full
// Build option: define UART_RX_MAJORITY_EN to evaluate each bit by a 2-of-3
// vote over the last three oversample ticks instead of a single sample.
module uart_rx import uart_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_divider,
  input  logic       rx_pop,
  input  logic       clear_err,
  output logic [7:0] rx_data_out,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overrun
);

  logic [1:0] sync_q;
  logic       rxs;
  logic [7:0] tick_cnt_q;
  logic       tick;
  rx_state_e  state_q;
  logic [3:0] sample_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       frame_error_q, frame_error_d;
  logic       overrun_q, overrun_d;
  logic       bit_v;
  logic       stop_eval, push, fe_evt, ov_evt;
  logic       fifo_full;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset) sync_q <= {HIGH, HIGH};
    else        sync_q <= {sync_q[0], rx_bit};
  end
  assign rxs = sync_q[1];

  // Oversample tick; >= also recovers promptly if the divider is lowered
  // while the counter is above the new value.
  assign tick = (tick_cnt_q >= freq_divider);
  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 8'd1;
  end

`ifdef UART_RX_MAJORITY_EN
  // Samples from the two ticks before the evaluation tick.
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (!reset)    hist_q <= {HIGH, HIGH};
    else if (tick) hist_q <= {hist_q[0], rxs};
  end
  assign bit_v = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_v = rxs;
`endif

  // Stop-bit outcome is decoded combinationally so the FIFO and flags update
  // on the evaluation edge itself and are visible the following cycle.
  assign stop_eval     = tick && (state_q == STOP) && (sample_cnt_q == 4'd15);
  assign push          = stop_eval &&  bit_v && (!fifo_full || rx_pop);
  assign ov_evt        = stop_eval &&  bit_v &&   fifo_full && !rx_pop;
  assign fe_evt        = stop_eval && !bit_v;
  // A new event wins over a same-cycle clear.
  assign frame_error_d = fe_evt | (frame_error_q & ~clear_err);
  assign overrun_d     = ov_evt | (overrun_q & ~clear_err);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (rxs == LOW) begin
              sample_cnt_q <= '0;
              state_q      <= START;
            end
          end
          START: begin
            if (sample_cnt_q == 4'd7) begin
              if (bit_v == LOW) begin
                sample_cnt_q <= '0;
                bit_cnt_q    <= '0;
                state_q      <= DATA;
              end else begin
                state_q <= IDLE;  // glitch, not a start bit
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
          DATA: begin
            if (sample_cnt_q == 4'd15) begin
              shift_q[bit_cnt_q] <= bit_v;
              sample_cnt_q       <= '0;
              if (bit_cnt_q == 3'd7) state_q   <= STOP;
              else                   bit_cnt_q <= bit_cnt_q + 3'd1;
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
          STOP: begin
            if (sample_cnt_q == 4'd15) begin
              sample_cnt_q <= '0;
              // A low stop bit parks in BREAK so a held-low line reports once.
              state_q      <= bit_v ? IDLE : BREAK;
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
          BREAK: begin
            if (rxs == HIGH) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign rx_full     = fifo_full;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (rx_pop),
    .data_in  (shift_q),
    .data_out (rx_data_out),
    .full     (fifo_full),
    .empty    (rx_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_bit = 1'b1;
  logic [7:0] freq_divider = 8'd0;
  logic       rx_pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_empty, rx_full, frame_error, overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .rx_pop       (rx_pop),
    .clear_err    (clear_err),
    .rx_data_out  (rx_data_out),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives npos positions of an 8N1 frame (start, d[0..7], stop), bt clocks
  // each, starting at a negedge. Position gpos is pulled low for one clock at
  // offset goff (gpos<0: no glitch).
  task automatic send(input logic [7:0] d, input logic stop, input int bt,
                      input int npos, input int gpos, input int goff);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int p = 0; p < npos; p++)
      for (int c = 0; c < bt; c++) begin
        rx_bit = (p == gpos && c == goff) ? 1'b0 : fr[p];
        @(negedge clk);
      end
  endtask

  // Pops every byte the scoreboard expects, checking order, then empty.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_nonempty"}, {7'd0, rx_empty}, 8'd0);
      chk({tag, "_data"}, rx_data_out, exp_q.pop_front());
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
    end
    chk({tag, "_empty"}, {7'd0, rx_empty}, 8'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_empty", {7'd0, rx_empty}, 8'd1);
    chk("rst_full",  {7'd0, rx_full}, 8'd0);
    chk("rst_data",  rx_data_out, 8'h00);
    chk("rst_fe",    {7'd0, frame_error}, 8'd0);
    chk("rst_ov",    {7'd0, overrun}, 8'd0);
    repeat (20) @(negedge clk);

    // 0xA5 at divider 0; push visible exactly one cycle after stop evaluation
    send(8'hA5, 1'b1, 16, 9, -1, 0);
    exp_q.push_back(8'hA5);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    chk("a5_pre_empty", {7'd0, rx_empty}, 8'd1);
    @(negedge clk);
    chk("a5_post_empty", {7'd0, rx_empty}, 8'd0);
    chk("a5_post_data", rx_data_out, exp_q[0]);
    chk("a5_fe", {7'd0, frame_error}, 8'd0);
    chk("a5_ov", {7'd0, overrun}, 8'd0);
    repeat (5) @(negedge clk);
    drain("a5");

    // Back-to-back frames at divider 6
    freq_divider = 8'd6;
    repeat (50) @(negedge clk);
    foreach (exp_q[i]) exp_q.delete(i);
    send(8'h00, 1'b1, 112, 10, -1, 0); exp_q.push_back(8'h00);
    send(8'hFF, 1'b1, 112, 10, -1, 0); exp_q.push_back(8'hFF);
    send(8'h55, 1'b1, 112, 10, -1, 0); exp_q.push_back(8'h55);
    rx_bit = 1'b1;
    repeat (20) @(negedge clk);
    chk("b2b_fe", {7'd0, frame_error}, 8'd0);
    chk("b2b_ov", {7'd0, overrun}, 8'd0);
    drain("b2b");
    freq_divider = 8'd0;
    repeat (40) @(negedge clk);

    // 4-clock glitch is rejected, receiver still works afterwards
    rx_bit = 1'b0;
    repeat (4) @(negedge clk);
    rx_bit = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_empty", {7'd0, rx_empty}, 8'd1);
    send(8'h96, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h96);
    repeat (4) @(negedge clk);
    drain("glitch");

    // Bad stop bit, then line held low (break)
    send(8'h3C, 1'b1, 16, 9, -1, 0);
    rx_bit = 1'b0;
    repeat (10) @(negedge clk);
    chk("fe_pre", {7'd0, frame_error}, 8'd0);
    @(negedge clk);
    chk("fe_rise", {7'd0, frame_error}, 8'd1);
    chk("fe_nopush", {7'd0, rx_empty}, 8'd1);
    repeat (5) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("fe_clear", {7'd0, frame_error}, 8'd0);
    repeat (40 * 16) @(negedge clk);
    chk("fe_once", {7'd0, frame_error}, 8'd0);
    chk("fe_break_empty", {7'd0, rx_empty}, 8'd1);
    rx_bit = 1'b1;
    repeat (32) @(negedge clk);
    send(8'h3C, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h3C);
    repeat (4) @(negedge clk);
    chk("fe_after", {7'd0, frame_error}, 8'd0);
    drain("fe");

    // Overrun: four frames fill the FIFO, fifth dropped
    send(8'h11, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h11);
    send(8'h22, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h22);
    send(8'h33, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h33);
    send(8'h44, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h44);
    chk("ov_full4", {7'd0, rx_full}, 8'd1);
    send(8'h55, 1'b1, 16, 9, -1, 0);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    chk("ov_pre", {7'd0, overrun}, 8'd0);
    @(negedge clk);
    chk("ov_rise", {7'd0, overrun}, 8'd1);
    chk("ov_full", {7'd0, rx_full}, 8'd1);
    chk("ov_head", rx_data_out, 8'h11);
    repeat (5) @(negedge clk);
    // Clear coinciding with a new overrun: flag stays set
    send(8'h66, 1'b1, 16, 9, -1, 0);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("ov_clr_race", {7'd0, overrun}, 8'd1);
    repeat (5) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("ov_clear", {7'd0, overrun}, 8'd0);
    // Pop in the stop-evaluation cycle lets the byte in
    send(8'h77, 1'b1, 16, 9, -1, 0);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    chk("ovpop_head", rx_data_out, exp_q.pop_front());
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    exp_q.push_back(8'h77);
    chk("ovpop_ov", {7'd0, overrun}, 8'd0);
    chk("ovpop_full", {7'd0, rx_full}, 8'd1);
    repeat (5) @(negedge clk);
    drain("ov");

    // Reset in the middle of data bit 4
    send(8'h5A, 1'b1, 16, 10, -1, 0);
    chk("mr_data", rx_data_out, 8'h5A);
    send(8'hC3, 1'b0, 16, 10, -1, 0);
    rx_bit = 1'b1;
    repeat (32) @(negedge clk);
    chk("mr_fe", {7'd0, frame_error}, 8'd1);
    send(8'h81, 1'b1, 16, 5, -1, 0);
    rx_bit = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    rx_bit = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    chk("mr_empty", {7'd0, rx_empty}, 8'd1);
    chk("mr_full",  {7'd0, rx_full}, 8'd0);
    chk("mr_data0", rx_data_out, 8'h00);
    chk("mr_fe0",   {7'd0, frame_error}, 8'd0);
    chk("mr_ov0",   {7'd0, overrun}, 8'd0);
    repeat (32) @(negedge clk);
    send(8'h81, 1'b1, 16, 10, -1, 0); exp_q.push_back(8'h81);
    repeat (4) @(negedge clk);
    drain("mr");

    // One-clock low pulse landing on sample 14 of data bit 2
    send(8'hFF, 1'b1, 16, 10, 3, 7); exp_q.push_back(8'hFF);
`ifdef UART_RX_MAJORITY_EN
    // Pulse landing on the evaluation sample itself is outvoted
    send(8'hFF, 1'b1, 16, 10, 3, 8); exp_q.push_back(8'hFF);
`endif
    repeat (4) @(negedge clk);
    drain("maj");
    chk("end_fe", {7'd0, frame_error}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
